// File: rtl/sgm_scan_ctrl.sv
// Raster scan controller: accepts real image pixels only, tracks column/row,
// drives the delay-line clock-enable and the neighbour-validity flags.
module sgm_scan_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 100,
    parameter int IMG_HEIGHT = 100,
    parameter int COL_W      = 12,
    parameter int ROW_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  de_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ce,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [COL_W-1:0]      column,
    output logic [ROW_W-1:0]      row,
    output logic                  valid_left,
    output logic                  valid_top,
    output logic                  valid_top_left,
    output logic                  valid_top_right,
    output logic                  line_end,
    output logic                  frame_end,
    output logic                  err_overrun,
    output logic                  err_underrun
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_FRAME, LINE, PORCH, DONE} state_t;

    state_t           state;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             gap_req;

    logic             acc;
    logic             surplus;
    logic             short_line;
    logic [COL_W-1:0] acc_col;
    logic [ROW_W-1:0] acc_row;
    logic             last_col;
    logic             last_row;

    // gap_req: a line just completed and de_in has not yet dropped, so any
    // further de_in pixels belong to an overlong line, not a new one.
    always_comb begin
        acc        = 1'b0;
        surplus    = 1'b0;
        short_line = 1'b0;
        acc_col    = col_cnt;
        acc_row    = row_cnt;
        if (frame_start) begin
            acc     = de_in;
            acc_col = '0;
            acc_row = '0;
        end else begin
            case (state)
                LINE:  begin
                    acc        = de_in;
                    short_line = ~de_in;
                end
                PORCH: begin
                    acc     = de_in & ~gap_req;
                    surplus = de_in & gap_req;
                end
                DONE:  surplus = de_in;
                default: ;
            endcase
        end
        last_col = (acc_col == LAST_COL);
        last_row = (acc_row == LAST_ROW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WAIT_FRAME;
            col_cnt         <= '0;
            row_cnt         <= '0;
            gap_req         <= 1'b0;
            ce              <= 1'b0;
            data_out        <= '0;
            column          <= '0;
            row             <= '0;
            valid_left      <= 1'b0;
            valid_top       <= 1'b0;
            valid_top_left  <= 1'b0;
            valid_top_right <= 1'b0;
            line_end        <= 1'b0;
            frame_end       <= 1'b0;
            err_overrun     <= 1'b0;
            err_underrun    <= 1'b0;
        end else begin
            data_out        <= data_in;
            ce              <= acc;
            line_end        <= acc & last_col;
            frame_end       <= acc & last_col & last_row;
            valid_left      <= acc & (acc_col != '0);
            valid_top       <= acc & (acc_row != '0);
            valid_top_left  <= acc & (acc_row != '0) & (acc_col != '0);
            valid_top_right <= acc & (acc_row != '0) & ~last_col;

            if (acc || frame_start) begin
                column <= acc_col;
                row    <= acc_row;
            end

            if (frame_start) begin
                err_overrun  <= 1'b0;
                err_underrun <= 1'b0;
            end else begin
                if (surplus)    err_overrun  <= 1'b1;
                if (short_line) err_underrun <= 1'b1;
            end

            if (acc) begin
                if (last_col) begin
                    col_cnt <= '0;
                    gap_req <= 1'b1;
                    if (last_row) begin
                        row_cnt <= acc_row;
                        state   <= DONE;
                    end else begin
                        row_cnt <= acc_row + 1'b1;
                        state   <= PORCH;
                    end
                end else begin
                    col_cnt <= acc_col + 1'b1;
                    row_cnt <= acc_row;
                    gap_req <= 1'b0;
                    state   <= LINE;
                end
            end else if (frame_start) begin
                col_cnt <= '0;
                row_cnt <= '0;
                gap_req <= 1'b0;
                state   <= PORCH;
            end else if (short_line) begin
                col_cnt <= '0;
                gap_req <= 1'b0;
                if (row_cnt == LAST_ROW) begin
                    state <= DONE;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                    state   <= PORCH;
                end
            end else if (state == PORCH && !de_in) begin
                gap_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sgm_scan_ctrl.sv
// Directed bench for sgm_scan_ctrl (100x4 image); includes a behavioural
// 100-deep delay line clocked by ce to confirm vertical alignment.
module tb_sgm_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        de_in;
    logic [11:0] data_in;
    logic        ce;
    logic [11:0] data_out;
    logic [11:0] column;
    logic [11:0] row;
    logic        valid_left, valid_top, valid_top_left, valid_top_right;
    logic        line_end, frame_end, err_overrun, err_underrun;

    sgm_scan_ctrl #(
        .DATA_WIDTH (12),
        .IMG_WIDTH  (100),
        .IMG_HEIGHT (4),
        .COL_W      (12),
        .ROW_W      (12)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .de_in           (de_in),
        .data_in         (data_in),
        .ce              (ce),
        .data_out        (data_out),
        .column          (column),
        .row             (row),
        .valid_left      (valid_left),
        .valid_top       (valid_top),
        .valid_top_left  (valid_top_left),
        .valid_top_right (valid_top_right),
        .line_end        (line_end),
        .frame_end       (frame_end),
        .err_overrun     (err_overrun),
        .err_underrun    (err_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int r, input int c, input int s);
        return 12'((s << 9) ^ (r << 7) ^ c);
    endfunction

    // Stimulus-owned controls
    int salt   = 0;
    bit seq_en = 0;
    bit dl_en  = 0;

    // Monitor-owned statistics
    int ce_cnt = 0, le_cnt = 0, fe_cnt = 0;
    int seq_err = 0, flag_err = 0, dl_err = 0, dl_cmp = 0, dp_err = 0;
    int seq_idx = 0, last_col = 0, last_row = 0, fe_col = -1, fe_row = -1;
    int rp = 0;
    logic [11:0] last_din = '0;
    logic        prev_rst = 1'b0;
    logic [11:0] ring [100];
    logic [3:0]  f_r0c5 = '0, f_r2c0 = '0, f_r1c99 = '0;

    always @(negedge clk) begin
        logic [11:0] dl_q;
        logic [3:0]  fl, fexp;
        if (rst_n && prev_rst && data_out !== last_din) dp_err++;
        last_din = data_in;
        prev_rst = rst_n;
        fl = {valid_left, valid_top, valid_top_left, valid_top_right};
        if (ce) begin
            ce_cnt++;
            last_col = int'(column);
            last_row = int'(row);
            if (line_end) le_cnt++;
            if (frame_end) begin
                fe_cnt++;
                fe_col = int'(column);
                fe_row = int'(row);
            end
            fexp = {column != 0, row != 0, row != 0 && column != 0, row != 0 && column != 99};
            if (fl !== fexp || line_end !== (column == 99) ||
                frame_end !== (column == 99 && row == 3)) flag_err++;
            if (seq_en && (int'(column) != seq_idx % 100 || int'(row) != seq_idx / 100)) seq_err++;
            dl_q = ring[rp];
            if (dl_en) begin
                if (data_out !== pix(int'(row), int'(column), salt)) dl_err++;
                if (valid_top) begin
                    dl_cmp++;
                    if (dl_q !== pix(int'(row) - 1, int'(column), salt)) dl_err++;
                end
            end
            ring[rp] = data_out;
            rp = (rp + 1) % 100;
            if (row == 0 && column == 5)  f_r0c5  = fl;
            if (row == 2 && column == 0)  f_r2c0  = fl;
            if (row == 1 && column == 99) f_r1c99 = fl;
            seq_idx++;
        end else if (fl != 4'b0 || line_end || frame_end) begin
            flag_err++;
        end
        if (frame_start) seq_idx = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int r, input int n, input int porch, input bit fs_first);
        for (int i = 0; i < n; i++) begin
            de_in       = 1'b1;
            data_in     = pix(r, i, salt);
            frame_start = fs_first && (i == 0);
            tick();
        end
        frame_start = 1'b0;
        de_in       = 1'b0;
        for (int i = 0; i < porch; i++) begin
            data_in = 12'($urandom);
            tick();
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    function automatic logic [50:0] out_vec();
        return {ce, data_out, column, row, valid_left, valid_top, valid_top_left,
                valid_top_right, line_end, frame_end, err_overrun, err_underrun};
    endfunction

    initial begin
        int b_ce, b_le, b_fe, b_seq, b_flag, b_dl, b_cmp;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        de_in       = 1'b0;
        data_in     = 12'h5a5;
        repeat (3) tick();
        check("reset_outputs", 32'(out_vec() != '0), 32'd0);
        rst_n = 1'b1;
        tick();

        // de_in ignored before any frame_start
        b_ce = ce_cnt;
        drive_line(0, 20, 3, 1'b0);
        check("wait_ignore_ce", ce_cnt - b_ce, 0);

        // Normal frame: 4 x 100, porch 10
        salt = 1; seq_en = 1; dl_en = 1;
        b_ce = ce_cnt; b_le = le_cnt; b_fe = fe_cnt; b_seq = seq_err;
        b_flag = flag_err; b_dl = dl_err; b_cmp = dl_cmp;
        pulse_fs();
        for (int r = 0; r < 4; r++) drive_line(r, 100, 10, 1'b0);
        check("norm_ce_count", ce_cnt - b_ce, 400);
        check("norm_line_end", le_cnt - b_le, 4);
        check("norm_frame_end", fe_cnt - b_fe, 1);
        check("norm_fe_col", fe_col, 99);
        check("norm_fe_row", fe_row, 3);
        check("norm_seq", seq_err - b_seq, 0);
        check("norm_flags", flag_err - b_flag, 0);
        check("norm_dline", dl_err - b_dl, 0);
        check("norm_dline_cmp", dl_cmp - b_cmp, 300);
        check("norm_err_over", 32'(err_overrun), 0);
        check("norm_err_under", 32'(err_underrun), 0);
        check("flags_r0c5", 32'(f_r0c5), 32'b1000);
        check("flags_r2c0", 32'(f_r2c0), 32'b0101);
        check("flags_r1c99", 32'(f_r1c99), 32'b1110);

        // Overrun: first line 103 pixels
        salt = 2;
        b_ce = ce_cnt; b_seq = seq_err; b_dl = dl_err; b_fe = fe_cnt;
        pulse_fs();
        drive_line(0, 103, 10, 1'b0);
        check("ovr_ce_line0", ce_cnt - b_ce, 100);
        check("ovr_err_over", 32'(err_overrun), 1);
        check("ovr_err_under", 32'(err_underrun), 0);
        for (int r = 1; r < 4; r++) drive_line(r, 100, 10, 1'b0);
        check("ovr_ce_total", ce_cnt - b_ce, 400);
        check("ovr_seq", seq_err - b_seq, 0);
        check("ovr_dline", dl_err - b_dl, 0);
        check("ovr_frame_end", fe_cnt - b_fe, 1);
        check("ovr_sticky", 32'(err_overrun), 1);

        // Underrun on row 1, then a surplus 5th line
        salt = 3; seq_en = 0; dl_en = 0;
        b_ce = ce_cnt; b_le = le_cnt; b_fe = fe_cnt;
        drive_line(0, 100, 5, 1'b1);
        check("und_clear_over", 32'(err_overrun), 0);
        drive_line(1, 97, 5, 1'b0);
        check("und_err_under", 32'(err_underrun), 1);
        check("und_line_end", le_cnt - b_le, 1);
        check("und_ce", ce_cnt - b_ce, 197);
        check("und_last_pos", 32'(last_row * 1000 + last_col), 32'd1096);
        drive_line(2, 100, 5, 1'b0);
        drive_line(3, 100, 5, 1'b0);
        check("und_frame_end", fe_cnt - b_fe, 1);
        check("und_last_row3", 32'(last_row * 1000 + last_col), 32'd3099);
        check("und_le_total", le_cnt - b_le, 3);
        check("und_no_over", 32'(err_overrun), 0);
        drive_line(4, 100, 5, 1'b0);
        check("surplus_ce", ce_cnt - b_ce, 397);
        check("surplus_err_over", 32'(err_overrun), 1);

        // Abort at row 2 column 50 with de_in high
        salt = 4;
        pulse_fs();
        drive_line(0, 101, 10, 1'b0);
        check("abort_pre_over", 32'(err_overrun), 1);
        drive_line(1, 100, 10, 1'b0);
        for (int i = 0; i < 50; i++) begin
            de_in = 1'b1;
            data_in = pix(2, i, salt);
            tick();
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort_pos", 32'({ce, column, row}), 32'({1'b1, 12'd0, 12'd0}));
        check("abort_errs", 32'({err_overrun, err_underrun}), 32'd0);
        b_le = le_cnt;
        for (int i = 1; i < 100; i++) tick();
        de_in = 1'b0;
        repeat (3) tick();
        check("abort_line_end", le_cnt - b_le, 1);
        check("abort_last_pos", 32'(last_row * 1000 + last_col), 32'd99);

        // Asynchronous reset in the middle of row 1
        de_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = pix(1, i, salt);
            tick();
        end
        check("pre_reset_ce", 32'(ce), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(out_vec() != '0), 32'd0);
        de_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Delay-line alignment across porch lengths
        seq_en = 1; dl_en = 1;
        for (int k = 0; k < 3; k++) begin
            int porch;
            bit fsf;
            porch = (k == 0) ? 1 : (k == 1) ? 10 : 37;
            fsf   = (k == 2);
            salt  = 5 + k;
            b_ce = ce_cnt; b_seq = seq_err; b_dl = dl_err; b_cmp = dl_cmp;
            if (!fsf) pulse_fs();
            for (int r = 0; r < 4; r++) drive_line(r, 100, porch, fsf && r == 0);
            check($sformatf("dl_p%0d_ce", porch), ce_cnt - b_ce, 400);
            check($sformatf("dl_p%0d_seq", porch), seq_err - b_seq, 0);
            check($sformatf("dl_p%0d_data", porch), dl_err - b_dl, 0);
            check($sformatf("dl_p%0d_cmp", porch), dl_cmp - b_cmp, 300);
        end

        check("flags_overall", flag_err, 0);
        check("datapath_delay", dp_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
